// File: rtl/clock_shield_pkg.sv
// Shared constants, timing helpers and types for the clock shield button logic.
// Cycle counts are derived from CLK_HZ so the button timings follow the system clock.
package clock_shield_pkg;

    localparam int CLK_HZ           = 50_000_000;
    localparam int DEBOUNCE_MS      = 20;
    localparam int REPEAT_DELAY_MS  = 500;
    localparam int REPEAT_PERIOD_MS = 100;

    function automatic int ms_to_cycles(input int ms);
        return (CLK_HZ / 1000) * ms;
    endfunction

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        REPEAT
    } hold_state_t;

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-flop synchroniser, stable-count debounce filter, edge pulses
// and, with BTN_DEBOUNCE_REPEAT_EN defined, a hold-to-auto-repeat FSM.
module debounce_channel
    import clock_shield_pkg::*;
#(
    parameter int STABLE_CYCLES = ms_to_cycles(DEBOUNCE_MS),
    parameter int ACTIVE_LOW    = 0,
    parameter int REPEAT_DELAY  = ms_to_cycles(REPEAT_DELAY_MS),
    parameter int REPEAT_PERIOD = ms_to_cycles(REPEAT_PERIOD_MS)
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_repeat
);

    localparam int             CW          = $clog2(STABLE_CYCLES);
    localparam logic [CW-1:0]  STABLE_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic           INVERT      = (ACTIVE_LOW != 0);
    localparam int             HOLD_MAX    = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int             HW          = $clog2(HOLD_MAX);

    if (STABLE_CYCLES < 2) begin : g_bad_stable
        $error("debounce_channel: STABLE_CYCLES must be >= 2");
    end
    if (REPEAT_DELAY < 2) begin : g_bad_delay
        $error("debounce_channel: REPEAT_DELAY must be >= 2");
    end
    if (REPEAT_PERIOD < 1) begin : g_bad_period
        $error("debounce_channel: REPEAT_PERIOD must be >= 1");
    end

    logic          s1;
    logic          s2;
    logic [CW-1:0] db_cnt;
    logic          flip;
    logic          rise_evt;
    logic          fall_evt;

    // A flip is due on the STABLE_CYCLES-th consecutive disagreeing cycle.
    always_comb begin
        flip     = (s2 != btn_level) && (db_cnt == STABLE_LAST);
        rise_evt = flip && !btn_level;
        fall_evt = flip && btn_level;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values; reset is synchronous and wins over all other inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1          <= 1'b0;
            s2          <= 1'b0;
            db_cnt      <= '0;
            btn_level   <= 1'b0;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
        end else begin
            s1          <= pin ^ INVERT;
            s2          <= s1;
            btn_press   <= rise_evt;
            btn_release <= fall_evt;
            if (s2 == btn_level) begin
                db_cnt <= '0;
            end else if (flip) begin
                btn_level <= ~btn_level;
                db_cnt    <= '0;
            end else begin
                db_cnt <= db_cnt + CW'(1);
            end
        end
    end

`ifdef BTN_DEBOUNCE_REPEAT_EN
    localparam logic [HW-1:0] DELAY_LAST  = HW'(REPEAT_DELAY - 1);
    localparam logic [HW-1:0] PERIOD_LAST = HW'(REPEAT_PERIOD - 1);

    hold_state_t   state;
    hold_state_t   state_n;
    logic [HW-1:0] hold_cnt;
    logic [HW-1:0] hold_cnt_n;
    logic          repeat_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            hold_cnt   <= '0;
            btn_repeat <= 1'b0;
        end else begin
            state      <= state_n;
            hold_cnt   <= hold_cnt_n;
            btn_repeat <= repeat_n;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_n    = state;
        hold_cnt_n = hold_cnt;
        repeat_n   = 1'b0;
        if (fall_evt) begin
            // Release outranks a repeat that falls due on the same edge.
            state_n    = IDLE;
            hold_cnt_n = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rise_evt) begin
                        state_n    = DELAY;
                        hold_cnt_n = '0;
                    end
                end
                DELAY: begin
                    if (hold_cnt == DELAY_LAST) begin
                        repeat_n   = 1'b1;
                        hold_cnt_n = '0;
                        state_n    = REPEAT;
                    end else begin
                        hold_cnt_n = hold_cnt + HW'(1);
                    end
                end
                REPEAT: begin
                    if (hold_cnt == PERIOD_LAST) begin
                        repeat_n   = 1'b1;
                        hold_cnt_n = '0;
                    end else begin
                        hold_cnt_n = hold_cnt + HW'(1);
                    end
                end
                default: begin
                    state_n    = IDLE;
                    hold_cnt_n = '0;
                end
            endcase
        end
    end
`else
    assign btn_repeat = 1'b0;
`endif

endmodule

// File: rtl/button_debouncer_bank.sv
// N independent debounced button channels with press/release pulses; hold-to-repeat
// pulses are built only when BTN_DEBOUNCE_REPEAT_EN is defined (otherwise btn_repeat = 0).
module button_debouncer_bank
    import clock_shield_pkg::*;
#(
    parameter int CHANNELS      = 3,
    parameter int STABLE_CYCLES = ms_to_cycles(DEBOUNCE_MS),
    parameter int ACTIVE_LOW    = 0,
    parameter int REPEAT_DELAY  = ms_to_cycles(REPEAT_DELAY_MS),
    parameter int REPEAT_PERIOD = ms_to_cycles(REPEAT_PERIOD_MS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] btn_in,
    output logic [CHANNELS-1:0] btn_level,
    output logic [CHANNELS-1:0] btn_press,
    output logic [CHANNELS-1:0] btn_release,
    output logic [CHANNELS-1:0] btn_repeat
);

    if (CHANNELS < 1) begin : g_bad_channels
        $error("button_debouncer_bank: CHANNELS must be >= 1");
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        debounce_channel #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .ACTIVE_LOW    (ACTIVE_LOW),
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .pin         (btn_in[i]),
            .btn_level   (btn_level[i]),
            .btn_press   (btn_press[i]),
            .btn_release (btn_release[i]),
            .btn_repeat  (btn_repeat[i])
        );
    end

endmodule

// File: tb/tb_button_debouncer_bank.sv
// Bench for button_debouncer_bank: directed scenarios plus random pin activity, checked
// against a rule-level model; an ACTIVE_LOW copy is driven with inverted pins in parallel.
module tb_button_debouncer_bank;

    localparam int CH = 3;
    localparam int SC = 4;
    localparam int RD = 10;
    localparam int RP = 3;
`ifdef BTN_DEBOUNCE_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [CH-1:0] btn;
    logic [CH-1:0] pins_n;
    logic [CH-1:0] lvl_a, prs_a, rel_a, rpt_a;
    logic [CH-1:0] lvl_b, prs_b, rel_b, rpt_b;

    assign pins_n = ~btn;

    button_debouncer_bank #(
        .CHANNELS(CH), .STABLE_CYCLES(SC), .ACTIVE_LOW(0), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk), .rst(rst), .btn_in(btn),
        .btn_level(lvl_a), .btn_press(prs_a), .btn_release(rel_a), .btn_repeat(rpt_a)
    );

    button_debouncer_bank #(
        .CHANNELS(CH), .STABLE_CYCLES(SC), .ACTIVE_LOW(1), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut_n (
        .clk(clk), .rst(rst), .btn_in(pins_n),
        .btn_level(lvl_b), .btn_press(prs_b), .btn_release(rel_b), .btn_repeat(rpt_b)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: pin history, consecutive-disagreement run length, press timestamps.
    logic [CH-1:0] m_s1 = '0, m_s2 = '0, m_lvl = '0;
    logic [CH-1:0] e_press = '0, e_rel = '0, e_rpt = '0;
    int            run[CH];
    bit            held[CH];
    int            press_at[CH];
    int            cyc = 0;

    task automatic chk(input string tag, input logic [CH-1:0] obs, input logic [CH-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s @cyc %0d observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_lvl = '0;
            e_press = '0; e_rel = '0; e_rpt = '0;
            for (int c = 0; c < CH; c++) begin
                run[c]  = 0;
                held[c] = 1'b0;
            end
        end else begin
            for (int c = 0; c < CH; c++) begin
                e_press[c] = 1'b0;
                e_rel[c]   = 1'b0;
                e_rpt[c]   = 1'b0;
                if (m_s2[c] != m_lvl[c]) begin
                    run[c]++;
                    if (run[c] == SC) begin
                        m_lvl[c] = ~m_lvl[c];
                        run[c]   = 0;
                        if (m_lvl[c]) e_press[c] = 1'b1;
                        else          e_rel[c]   = 1'b1;
                    end
                end else begin
                    run[c] = 0;
                end
                if (e_press[c]) begin
                    held[c]     = 1'b1;
                    press_at[c] = cyc;
                end
                if (e_rel[c]) held[c] = 1'b0;
                if (REP_EN && held[c] && (cyc - press_at[c]) >= RD &&
                    ((cyc - press_at[c] - RD) % RP) == 0)
                    e_rpt[c] = 1'b1;
                m_s2[c] = m_s1[c];
                m_s1[c] = btn[c];
            end
        end
        cyc++;
    endtask

    task automatic check_all();
        chk("level",       lvl_a, m_lvl);
        chk("press",       prs_a, e_press);
        chk("release",     rel_a, e_rel);
        chk("repeat",      rpt_a, e_rpt);
        chk("level_al",    lvl_b, m_lvl);
        chk("press_al",    prs_b, e_press);
        chk("release_al",  rel_b, e_rel);
        chk("repeat_al",   rpt_b, e_rpt);
    endtask

    // One clock: model follows the active edge, outputs are compared on the falling edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic settle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Edge index (0 = first edge after the pin change) of the next pulse; -1 if none in budget.
    task automatic wait_edge(input int ch, input bit rise, output int edges);
        edges = -1;
        for (int i = 0; i < 20; i++) begin
            step();
            if ((rise ? prs_a[ch] : rel_a[ch]) === 1'b1) begin
                edges = i;
                break;
            end
        end
    endtask

    initial begin
        int e, nrep, first, last, pre;
        rst = 1'b1;
        btn = '0;
        step();
        step();
        chk("reset_level",  lvl_a, '0);
        chk("reset_pulses", prs_a | rel_a | rpt_a, '0);
        rst = 1'b0;
        settle(3);

        // Clean press and release on channel 0.
        btn[0] = 1'b1;
        wait_edge(0, 1'b1, e);
        chk_int("clean_press_edge", e, 5);
        chk("clean_press_only_ch0", prs_a, 3'b001);
        step();
        chk("clean_press_one_cycle", prs_a, 3'b000);
        btn[0] = 1'b0;
        wait_edge(0, 1'b0, e);
        chk_int("clean_release_edge", e, 5);
        settle(4);

        // Bounce on channel 1, then a steady press.
        pre = 0;
        for (int k = 0; k < 4; k++) begin
            btn[1] = (k % 2 == 0);
            step();
            pre += prs_a[1];
            step();
            pre += prs_a[1];
        end
        chk_int("bounce_no_pulse", pre, 0);
        btn[1] = 1'b1;
        wait_edge(1, 1'b1, e);
        chk_int("bounce_final_press_edge", e, 5);
        btn[1] = 1'b0;
        settle(10);

        // Hold channel 2 for 30 cycles after its press.
        btn[2] = 1'b1;
        wait_edge(2, 1'b1, e);
        chk_int("hold_press_edge", e, 5);
        nrep = 0; first = -1; last = -1;
        for (int k = 1; k <= 30; k++) begin
            step();
            if (rpt_a[2] === 1'b1) begin
                nrep++;
                if (first < 0) first = k;
                last = k;
            end
        end
        chk_int("repeat_count",  nrep,  REP_EN ? 7  : 0);
        chk_int("repeat_first",  first, REP_EN ? 10 : -1);
        chk_int("repeat_last",   last,  REP_EN ? 28 : -1);
        btn[2] = 1'b0;
        wait_edge(2, 1'b0, e);
        chk_int("hold_release_edge", e, 5);
        settle(10);

        // Release pulse landing on a due repeat (+19) suppresses it.
        btn[2] = 1'b1;
        wait_edge(2, 1'b1, e);
        for (int k = 1; k <= 13; k++) step();
        btn[2] = 1'b0;
        for (int k = 14; k <= 19; k++) step();
        chk("release_at_19",        rel_a, 3'b100);
        chk("repeat_suppressed_19", rpt_a, 3'b000);
        settle(12);

        // All channels rise together.
        btn = 3'b111;
        wait_edge(0, 1'b1, e);
        chk_int("simul_press_edge", e, 5);
        chk("simul_press_all",    prs_a, 3'b111);
        chk("simul_press_all_al", prs_b, 3'b111);
        btn = 3'b000;
        wait_edge(0, 1'b0, e);
        chk("simul_release_all", rel_a, 3'b111);
        settle(6);

        // Reset with the filter counter at 3, then again while the level is held high.
        btn[0] = 1'b1;
        settle(5);
        rst = 1'b1;
        step();
        chk("rst_mid_count_outputs", lvl_a | prs_a | rel_a | rpt_a, '0);
        rst = 1'b0;
        wait_edge(0, 1'b1, e);
        chk_int("rst_mid_count_press_edge", e, 5);
        settle(3);
        rst = 1'b1;
        step();
        chk("rst_mid_hold_level", lvl_a, '0);
        rst = 1'b0;
        wait_edge(0, 1'b1, e);
        chk_int("rst_mid_hold_press_edge", e, 5);
        btn = '0;
        settle(8);

        // Random pin activity: short bounces first, then long holds for repeats.
        for (int i = 0; i < 300; i++) begin
            for (int c = 0; c < CH; c++)
                if ($urandom_range(0, 7) == 0) btn[c] = ~btn[c];
            rst = ($urandom_range(0, 149) == 0);
            step();
        end
        rst = 1'b0;
        for (int i = 0; i < 400; i++) begin
            for (int c = 0; c < CH; c++)
                if ($urandom_range(0, 39) == 0) btn[c] = ~btn[c];
            step();
        end
        btn = '0;
        settle(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/button_debouncer_bank.md
Name: button_debouncer_bank

Overview:
- Parametrised N-channel successor to the single-button debouncer used for the clock shield's up, down and select buttons.
- Each channel provides:
  - a 2-flop synchroniser;
  - a stable-count debounce filter;
  - a debounced level;
  - one-cycle press and release pulses;
  - optional hold-to-auto-repeat pulses, used for fast time-set scrolling.
- Sits between raw shield button pins and the clock UI / time-set FSM.

Parameters:
- CHANNELS, 3, number of independent button channels (>=1).
- STABLE_CYCLES, 1000000, consecutive cycles of disagreement required before the level flips (20 ms @ 50 MHz; >=2).
- ACTIVE_LOW, 0, 1 = raw input inverted before the synchroniser (pressed = pin low).
- REPEAT_DELAY, 25000000, cycles from press pulse to first repeat pulse (500 ms; >=2).
- REPEAT_PERIOD, 5000000, cycles between subsequent repeat pulses (100 ms; >=1).

Ports:
- clk, input, 1, system clock (50 MHz).
- rst, input, 1, synchronous active-high reset.
- btn_in, input, CHANNELS, raw asynchronous button pins.
- btn_level, output, CHANNELS, debounced level, 1 = pressed.
- btn_press, output, CHANNELS, one-cycle pulse on debounced 0->1.
- btn_release, output, CHANNELS, one-cycle pulse on debounced 1->0.
- btn_repeat, output, CHANNELS, one-cycle auto-repeat pulse while held.

Interface decision: one clock (clk); reset rst is synchronous and active-high.

Behaviour:
- Reset: all outputs 0; sync flops 0; all counters 0. Applies to every channel in the cycle rst is sampled high, including mid-count and mid-hold. rst overrides all other inputs.
- Synchroniser: s1 <= btn_in ^ ACTIVE_LOW; s2 <= s1.
- Debounce counter: per channel, width $clog2(STABLE_CYCLES).
  - s2 == btn_level: counter cleared. Any single agreeing cycle restarts the count (glitch rejection).
  - s2 != btn_level and counter < STABLE_CYCLES-1: counter increments.
  - s2 != btn_level and counter == STABLE_CYCLES-1: btn_level toggles, counter clears, and btn_press or btn_release asserts for exactly that one cycle.
- Latency: a clean input change sampled at edge 0 updates btn_level and the pulse on edge STABLE_CYCLES+1, i.e. the (STABLE_CYCLES+2)th edge.
- Pulse exclusivity: press and release never assert together on one channel. Channels are fully independent; simultaneous events on different channels all pulse in the same cycle.
- Power-up / reset with button held: the level comes up 0, then a normal press pulse follows after the debounce latency.
- Hold FSM (per channel, states IDLE, DELAY, REPEAT), with hold counter width $clog2(max(REPEAT_DELAY, REPEAT_PERIOD)):
  - IDLE -> DELAY on the press pulse; hold counter cleared.
  - DELAY: counter increments each cycle. At REPEAT_DELAY-1, btn_repeat pulses, counter clears, and the FSM goes to REPEAT.
  - REPEAT: counter increments. At REPEAT_PERIOD-1, btn_repeat pulses and the counter clears.
  - Any state -> IDLE on the release pulse, counter cleared. A release pulse in the same cycle as a due repeat suppresses the repeat.
  - Repeat pulses land REPEAT_DELAY + k*REPEAT_PERIOD cycles after the press pulse (k >= 0).
  - btn_press itself is not duplicated on btn_repeat; consumers OR the two.

Optional Feature:
- Macro: BTN_DEBOUNCE_REPEAT_EN.
- Defined: hold FSM and hold counters are built; btn_repeat behaves as above.
- Undefined: no hold logic is synthesised; btn_repeat is tied to 0; the port list is unchanged.

Decomposition:
- Shared package clock_shield_pkg:
  - CLK_HZ = 50000000;
  - ms-to-cycles constant function;
  - default DEBOUNCE_MS = 20, REPEAT_DELAY_MS = 500, REPEAT_PERIOD_MS = 100;
  - hold-state typedef (IDLE, DELAY, REPEAT).
- Sub-module debounce_channel: one channel (synchroniser + filter + hold FSM), generated CHANNELS times by button_debouncer_bank.
- Elaboration-time assertions on the parameter minimums.

Test Plan:
All scenarios use simulation parameters CHANNELS=3, STABLE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
1. Clean press: btn_in[0] rises before edge 0 -> btn_level[0]=1 and btn_press[0]=1 at edge 5 only; other channels stay 0. Release mirrors this with btn_release.
2. Bounce: btn_in[1] toggles 1,0,1,0 on alternate cycles, then holds 1 -> no pulse during the bounce; btn_press[1] at edge 5 counted from the final rise.
3. Auto-repeat (macro on): hold ch2 for 30 cycles after its press pulse -> btn_repeat[2] at +10, +13, +16, ..., +28. Release at +19 (repeat due) -> repeat suppressed, no further repeats. Macro off: btn_repeat stays 0.
4. Simultaneous: all three inputs rise on the same edge -> all three press pulses in the same cycle. ACTIVE_LOW=1 with pins falling -> identical response.
5. Reset mid-operation: rst asserted for 1 cycle at counter=3 while held -> outputs 0 next cycle. With the input still high, a press pulse re-occurs 5 edges after rst deasserts (sync path refills from 0).
